// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared SM3 constants, FSM state type and initial hash value
package sm3_pkg;

    localparam int SM3_BLK_W = 512;
    localparam int SM3_LEN_W = 64;
    localparam logic [7:0] SM3_PAD_BYTE = 8'h80;

    // Initial chaining value, reloaded by the compression core on blk_first
    localparam logic [255:0] SM3_IV = {
        32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
        32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
    };

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        EMIT,
        PAD2
    } sm3_state_t;

endpackage

// File: rtl/sm3_msg_padder_if.sv
// rtl/sm3_msg_padder_if.sv - message word input and 512-bit block output channels
interface sm3_msg_padder_if
    import sm3_pkg::*;
#(
    parameter int IN_W = 32
);
    localparam int BE_W = $clog2(IN_W / 8);

    logic                 valid_in;
    logic [IN_W-1:0]      msg_in;
    logic                 last_in;
    logic [BE_W-1:0]      last_bytes;
    logic                 hold_pipline;
    logic                 blk_valid;
    logic                 blk_ready;
    logic [SM3_BLK_W-1:0] blk_data;
    logic                 blk_first;
    logic                 blk_last;

    modport master (
        output valid_in, msg_in, last_in, last_bytes, blk_ready,
        input  hold_pipline, blk_valid, blk_data, blk_first, blk_last
    );

    modport slave (
        input  valid_in, msg_in, last_in, last_bytes, blk_ready,
        output hold_pipline, blk_valid, blk_data, blk_first, blk_last
    );

endinterface

// File: rtl/sm3_byte_merge.sv
// rtl/sm3_byte_merge.sv - writes n message bytes plus optional 0x80 marker at a byte pointer
module sm3_byte_merge
    import sm3_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic [SM3_BLK_W-1:0]      buf_in,
    input  logic [6:0]                ptr,
    input  logic [IN_W-1:0]           word,
    input  logic [$clog2(IN_W/8):0]   n_bytes,
    input  logic                      mark,
    output logic [SM3_BLK_W-1:0]      buf_out
);

    function automatic logic [7:0] get_byte(input logic [IN_W-1:0] w, input int k);
        logic [IN_W-1:0] s;
        s = w << (8 * k);
        return s[IN_W-1 -: 8];
    endfunction

    // Bytes below the pointer are kept; everything from the pointer up is rebuilt,
    // so stale content above the write never leaks into a block
    always_comb begin
        buf_out = '0;
        for (int i = 0; i < 64; i++) begin
            int rel;
            rel = i - int'(ptr);
            if (rel < 0) begin
                buf_out[511-8*i -: 8] = buf_in[511-8*i -: 8];
            end else if (rel < int'(n_bytes)) begin
                buf_out[511-8*i -: 8] = get_byte(word, rel);
            end else if (mark && (rel == int'(n_bytes))) begin
                buf_out[511-8*i -: 8] = SM3_PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sm3_msg_padder.sv
// rtl/sm3_msg_padder.sv - streaming SM3 padder producing 512-bit blocks for the compression core
module sm3_msg_padder
    import sm3_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    sm3_msg_padder_if.slave   bus,
    output logic              len_ovf
);

    localparam int NB   = IN_W / 8;
    localparam int BE_W = $clog2(NB);

    generate
        if (IN_W != 32 && IN_W != 64) begin : g_bad_in_w
            $error("sm3_msg_padder: IN_W must be 32 or 64");
        end
    endgenerate

    sm3_state_t           state;
    sm3_state_t           after_q;
    logic [SM3_BLK_W-1:0] buf_q;
    logic [SM3_BLK_W-1:0] merged;
    logic [6:0]           ptr_q;
    logic [6:0]           new_ptr;
    logic [SM3_LEN_W-1:0] bit_cnt_q;
    logic [SM3_LEN_W:0]   sum;
    logic [BE_W:0]        n_bytes;
    logic                 first_q;
    logic                 last_q;
    logic                 mark_q;
    logic                 ovf_q;

    always_comb begin
        n_bytes = (BE_W+1)'(NB);
        if (bus.last_in && (bus.last_bytes != '0)) begin
            n_bytes = {1'b0, bus.last_bytes};
        end
    end

    assign new_ptr = ptr_q + 7'(n_bytes);
    assign sum     = {1'b0, bit_cnt_q} + 65'({n_bytes, 3'b000});

    sm3_byte_merge #(.IN_W(IN_W)) u_merge (
        .buf_in  (buf_q),
        .ptr     (ptr_q),
        .word    (bus.msg_in),
        .n_bytes (n_bytes),
        .mark    (bus.last_in),
        .buf_out (merged)
    );

    assign bus.hold_pipline = (state == EMIT) || (state == PAD2);
    assign bus.blk_valid    = (state == EMIT);
    assign bus.blk_data     = buf_q;
    assign bus.blk_first    = first_q;
    assign bus.blk_last     = last_q;
    assign len_ovf          = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            after_q   <= IDLE;
            buf_q     <= '0;
            ptr_q     <= '0;
            bit_cnt_q <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            mark_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, FILL: begin
                    if (bus.valid_in) begin
                        if (state == IDLE) first_q <= 1'b1;
                        bit_cnt_q <= sum[SM3_LEN_W-1:0];
                        if (sum[SM3_LEN_W]) ovf_q <= 1'b1;
                        ptr_q <= new_ptr;
                        if (!bus.last_in) begin
                            buf_q   <= merged;
                            last_q  <= 1'b0;
                            after_q <= FILL;
                            state   <= (new_ptr == 7'd64) ? EMIT : FILL;
                        end else if (new_ptr <= 7'd55) begin
                            buf_q   <= {merged[SM3_BLK_W-1:SM3_LEN_W], sum[SM3_LEN_W-1:0]};
                            last_q  <= 1'b1;
                            after_q <= IDLE;
                            state   <= EMIT;
                        end else begin
                            // No room for the length field; marker goes to the PAD2
                            // block only when the data filled this block completely
                            buf_q   <= merged;
                            last_q  <= 1'b0;
                            mark_q  <= (new_ptr == 7'd64);
                            after_q <= PAD2;
                            state   <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (bus.blk_ready) begin
                        buf_q   <= '0;
                        ptr_q   <= '0;
                        first_q <= 1'b0;
                        state   <= after_q;
                        if (after_q == IDLE) bit_cnt_q <= '0;
                    end
                end
                PAD2: begin
                    buf_q   <= {(mark_q ? SM3_PAD_BYTE : 8'h00), 440'b0, bit_cnt_q};
                    last_q  <= 1'b1;
                    after_q <= IDLE;
                    state   <= EMIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_msg_padder.sv
// tb/tb_sm3_msg_padder.sv - directed table-driven bench for sm3_msg_padder
module tb_sm3_msg_padder;
    import sm3_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ovf32, ovf64;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sm3_msg_padder_if #(.IN_W(32)) if32 ();
    sm3_msg_padder_if #(.IN_W(64)) if64 ();

    sm3_msg_padder #(.IN_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave), .len_ovf(ovf32));
    sm3_msg_padder #(.IN_W(64)) u_dut64 (.clk(clk), .rst(rst), .bus(if64.slave), .len_ovf(ovf64));

    typedef struct {
        int     len;
        int     nblk;
        int     mark_blk;
        int     mark_byte;
        longint bitlen;
    } vec_t;

    vec_t vecs[7];
    vec_t v64a, v64b;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'b0, 32'h00000018};

    function automatic logic [7:0] pat(input int g);
        return 8'h61 + 8'(g % 4);
    endfunction

    function automatic logic [7:0] exp_byte(input vec_t v, input int b, input int j);
        int g;
        g = 64 * b + j;
        if (g < v.len) return pat(g);
        if (b == v.mark_blk && j == v.mark_byte) return 8'h80;
        if (b == v.nblk - 1 && j >= 56) return 8'(v.bitlen >> (8 * (63 - j)));
        return 8'h00;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_msg(input int sel, input int len);
        int nb, nw, cnt;
        logic [63:0] w64;
        logic h;
        nb = sel ? 8 : 4;
        nw = (len + nb - 1) / nb;
        @(posedge clk); #1;
        for (int w = 0; w < nw; w++) begin
            w64 = '0;
            for (int k = 0; k < nb; k++)
                if (w * nb + k < len) w64[63-8*k -: 8] = pat(w * nb + k);
            if (sel) begin
                if64.valid_in = 1'b1; if64.msg_in = w64;
                if64.last_in = (w == nw - 1); if64.last_bytes = 3'(len % 8);
            end else begin
                if32.valid_in = 1'b1; if32.msg_in = w64[63:32];
                if32.last_in = (w == nw - 1); if32.last_bytes = 2'(len % 4);
            end
            cnt = 0;
            forever begin
                @(negedge clk);
                h = sel ? if64.hold_pipline : if32.hold_pipline;
                if (!h) break;
                cnt++;
                if (cnt > 3000) begin
                    checks++; failures++;
                    $display("FAIL send_timeout actual=held required=accepted");
                    break;
                end
            end
            @(posedge clk); #1;
        end
        if (sel) if64.valid_in = 1'b0; else if32.valid_in = 1'b0;
    endtask

    task automatic collect(input int sel, input vec_t v, input string tag);
        int cnt;
        logic [511:0] exp;
        for (int b = 0; b < v.nblk; b++) begin
            cnt = 0;
            while (!(sel ? if64.blk_valid : if32.blk_valid) && cnt < 3000) begin
                @(negedge clk);
                cnt++;
            end
            if (!(sel ? if64.blk_valid : if32.blk_valid)) begin
                checks++; failures++;
                $display("FAIL %s_timeout actual=no_block required=block%0d", tag, b);
                return;
            end
            for (int j = 0; j < 64; j++) exp[511-8*j -: 8] = exp_byte(v, b, j);
            check($sformatf("%s_b%0d_data", tag, b), sel ? if64.blk_data : if32.blk_data, exp);
            check($sformatf("%s_b%0d_first", tag, b), sel ? if64.blk_first : if32.blk_first, (b == 0));
            check($sformatf("%s_b%0d_last", tag, b), sel ? if64.blk_last : if32.blk_last, (b == v.nblk - 1));
            check($sformatf("%s_b%0d_ovf", tag, b), sel ? ovf64 : ovf32, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3, 1, 0, 3, 24};
        vecs[1] = '{56, 2, 0, 56, 448};
        vecs[2] = '{64, 2, 1, 0, 512};
        vecs[3] = '{55, 1, 0, 55, 440};
        vecs[4] = '{5, 1, 0, 5, 40};
        vecs[5] = '{61, 2, 0, 61, 488};
        vecs[6] = '{100, 2, 1, 36, 800};
        v64a    = '{21, 1, 0, 21, 168};
        v64b    = '{16, 1, 0, 16, 128};

        if32.valid_in = 0; if32.msg_in = '0; if32.last_in = 0; if32.last_bytes = '0; if32.blk_ready = 1;
        if64.valid_in = 0; if64.msg_in = '0; if64.last_in = 0; if64.last_bytes = '0; if64.blk_ready = 1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_blk_valid", if32.blk_valid, 0);
        check("rst_hold", if32.hold_pipline, 0);
        check("rst_blk_data", if32.blk_data, 0);
        check("rst_blk_first", if32.blk_first, 0);
        check("rst_blk_last", if32.blk_last, 0);
        check("rst_len_ovf", ovf32, 0);
        check("rst64_blk_valid", if64.blk_valid, 0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            fork
                send_msg(0, vecs[i].len);
                collect(0, vecs[i], $sformatf("vec%0d_len%0d", i, vecs[i].len));
            join
        end

        fork
            send_msg(1, v64a.len);
            collect(1, v64a, "w64_len21");
        join
        fork
            send_msg(1, v64b.len);
            collect(1, v64b, "w64_len16");
        join

        // Core stalls on "abc" while the next message's first word waits on the bus
        if32.blk_ready = 1'b0;
        fork
            begin
                send_msg(0, 3);
                send_msg(0, 5);
            end
            begin
                int cnt;
                cnt = 0;
                while (!if32.blk_valid && cnt < 3000) begin
                    @(negedge clk);
                    cnt++;
                end
                check("stall_abc_const", if32.blk_data, ABC_BLK);
                check("stall_abc_first", if32.blk_first, 1);
                check("stall_abc_last", if32.blk_last, 1);
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    check($sformatf("stall_valid_%0d", k), if32.blk_valid, 1);
                    check($sformatf("stall_data_%0d", k), if32.blk_data, ABC_BLK);
                    check($sformatf("stall_hold_%0d", k), if32.hold_pipline, 1);
                end
                if32.blk_ready = 1'b1;
                collect(0, vecs[0], "stall_abc");
                collect(0, vecs[4], "stall_next");
            end
        join

        // Reset in the middle of a message discards the partial block
        @(posedge clk); #1;
        if32.valid_in = 1; if32.msg_in = 32'hdeadbeef; if32.last_in = 0;
        @(posedge clk); #1;
        if32.msg_in = 32'h01234567;
        @(posedge clk); #1;
        if32.valid_in = 0;
        rst = 1'b0;
        #1;
        check("midrst_blk_valid", if32.blk_valid, 0);
        check("midrst_hold", if32.hold_pipline, 0);
        check("midrst_blk_data", if32.blk_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        fork
            send_msg(0, 3);
            begin
                int cnt;
                cnt = 0;
                while (!if32.blk_valid && cnt < 3000) begin
                    @(negedge clk);
                    cnt++;
                end
                check("midrst_abc_const", if32.blk_data, ABC_BLK);
                collect(0, vecs[0], "midrst_abc");
            end
        join
        check("final_len_ovf", ovf32, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
